// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM slave: opcodes, FSM encoding and
// status register layout.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int ST_WIP_BIT = 0;
  localparam int ST_WEL_BIT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WRITE,
    S_READ,
    S_STATUS,
    S_IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] sb;
    sb             = 8'h00;
    sb[ST_WEL_BIT] = wel;
    sb[ST_WIP_BIT] = wip;
    return sb;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 byte engine: input synchronizers, SCK edge detect, bit counter
// and the receive/transmit shift registers, all in the clk domain.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       ss_i,
  input  logic       mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       sel_o,
  output logic       last_bit_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic [7:0] rx_next_o,
  output logic       miso_o
);

  logic [1:0] sck_sync_q, ss_sync_q, mosi_sync_q, arm_dly_q;
  logic       sck_prev_q, armed_q, done_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q;
  logic       sck_s, ss_s, mosi_s, rise, fall;

  assign sck_s  = sck_sync_q[1];
  assign ss_s   = ss_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  // Selection only counts once ss has been genuinely sampled high after reset,
  // so a reset in the middle of a transfer cannot resume it.
  assign sel_o = armed_q & ~ss_s;
  assign rise  = sel_o & sck_s & ~sck_prev_q;
  assign fall  = sel_o & ~sck_s & sck_prev_q;

  assign last_bit_o  = rise & (bit_cnt_q == 3'd7);
  assign byte_done_o = done_q & sel_o;
  assign rx_byte_o   = rx_q;
  assign rx_next_o   = {rx_q[6:0], mosi_s};
  assign miso_o      = tx_q[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      arm_dly_q   <= 2'b00;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      ss_sync_q   <= {ss_sync_q[0], ss_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      arm_dly_q   <= {arm_dly_q[0], 1'b1};
      sck_prev_q  <= sck_s;
      done_q      <= 1'b0;
      if (arm_dly_q[1] && ss_s) begin
        armed_q <= 1'b1;
      end
      if (!sel_o) begin
        bit_cnt_q <= 3'd0;
        rx_q      <= 8'h00;
        tx_q      <= 8'h00;
      end else begin
        if (rise) begin
          rx_q      <= {rx_q[6:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          done_q    <= (bit_cnt_q == 3'd7);
        end
        // The falling edge that follows a byte's last rise is skipped so a
        // freshly loaded byte keeps its MSB on the line.
        if (tx_load_i) begin
          tx_q <= tx_byte_i;
        end else if (fall && bit_cnt_q != 3'd0) begin
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_eeprom_slave.sv
// SPI EEPROM slave: command FSM, write-enable latch, write-cycle timer and a
// 256x8 memory behind the spi_slave_shifter byte engine.
module spi_eeprom_slave
  import spi_eeprom_pkg::*;
#(
  parameter int WRITE_CYCLES = 100,
  parameter int PAGE_SIZE    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic wip
);

  localparam int         CNT_W   = $clog2(WRITE_CYCLES + 1);
  localparam logic [7:0] PG_MASK = 8'(PAGE_SIZE - 1);

  state_e     state_q, state_d;
  logic       wel_q, wel_d, rd_q, rd_d, wrote_q, wrote_d;
  logic [7:0] addr_q, addr_d, page_next;
  logic [CNT_W-1:0] wip_cnt_q, wip_cnt_d;

  logic       sel, last_bit, byte_done, miso_sh, tx_load, mem_we, wip_busy;
  logic [7:0] rx_byte, rx_next, tx_byte, raddr, rdata_q;
  logic [7:0] mem_q [256];

  spi_slave_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (spi_sck),
    .ss_i       (spi_ss),
    .mosi_i     (spi_mosi),
    .tx_load_i  (tx_load),
    .tx_byte_i  (tx_byte),
    .sel_o      (sel),
    .last_bit_o (last_bit),
    .byte_done_o(byte_done),
    .rx_byte_o  (rx_byte),
    .rx_next_o  (rx_next),
    .miso_o     (miso_sh)
  );

  assign wip_busy    = (wip_cnt_q != '0);
  assign wip         = wip_busy;
  assign spi_miso_oe = sel && (state_q == S_READ || state_q == S_STATUS);
  assign spi_miso    = spi_miso_oe & miso_sh;
  assign page_next   = (addr_q & ~PG_MASK) | ((addr_q + 8'd1) & PG_MASK);

  always_comb begin
    state_d   = state_q;
    wel_d     = wel_q;
    rd_d      = rd_q;
    wrote_d   = wrote_q;
    addr_d    = addr_q;
    wip_cnt_d = wip_busy ? (wip_cnt_q - CNT_W'(1)) : '0;
    tx_load   = 1'b0;
    tx_byte   = rdata_q;
    mem_we    = 1'b0;
    raddr     = addr_q;
    if (!sel) begin
      if (state_q == S_WRITE && wrote_q) begin
        wip_cnt_d = CNT_W'(WRITE_CYCLES);
        wel_d     = 1'b0;
      end
      state_d = S_IDLE;
      wrote_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            unique case (rx_byte)
              OP_WREN: begin
                if (!wip_busy) wel_d = 1'b1;
                state_d = S_IGNORE;
              end
              OP_WRDI: begin
                if (!wip_busy) wel_d = 1'b0;
                state_d = S_IGNORE;
              end
              OP_RDSR: begin
                tx_load = 1'b1;
                tx_byte = status_byte(wel_q, wip_busy);
                state_d = S_STATUS;
              end
              OP_READ: begin
                rd_d    = 1'b1;
                state_d = S_ADDR;
              end
              OP_WRITE: begin
                rd_d    = 1'b0;
                state_d = (wel_q && !wip_busy) ? S_ADDR : S_IGNORE;
              end
              default: state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          // Fetch the first read byte as the address's last bit arrives so it
          // is ready to load the moment the address byte completes.
          if (last_bit) raddr = rx_next;
          if (byte_done) begin
            if (rd_q) begin
              tx_load = 1'b1;
              addr_d  = rx_byte + 8'd1;
              state_d = S_READ;
            end else begin
              addr_d  = rx_byte;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (byte_done) begin
            mem_we  = 1'b1;
            wrote_d = 1'b1;
            addr_d  = page_next;
          end
        end
        S_READ: begin
          if (byte_done) begin
            tx_load = 1'b1;
            addr_d  = addr_q + 8'd1;
          end
        end
        S_STATUS: begin
          if (byte_done) begin
            tx_load = 1'b1;
            tx_byte = status_byte(wel_q, wip_busy);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wel_q     <= 1'b0;
      rd_q      <= 1'b0;
      wrote_q   <= 1'b0;
      addr_q    <= 8'h00;
      wip_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wel_q     <= wel_d;
      rd_q      <= rd_d;
      wrote_q   <= wrote_d;
      addr_q    <= addr_d;
      wip_cnt_q <= wip_cnt_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= rx_byte;
    rdata_q <= mem_q[raddr];
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Bench for spi_eeprom_slave: SPI master tasks drive transactions, a reference
// model pushes expected MISO bytes, and a monitor on SCK pops and compares.
module tb_spi_eeprom_slave;

  localparam int W    = 300;
  localparam int PS   = 16;
  localparam int HALF = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, wip;

  spi_eeprom_slave #(.WRITE_CYCLES(W), .PAGE_SIZE(PS)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .wip        (wip)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] exp;
    logic [7:0] mask;
  } sb_t;

  sb_t        exp_q[$];
  int         total = 0, bad = 0;
  int         cyc = 0, wip_hi = 0, last_rise = 0, ss_rise = 0;
  int         wip_until = 0;
  bit         m_wel = 1'b0;
  logic [7:0] ref_mem [256];
  bit         known [256];
  logic [7:0] mon_sh = 8'h00;
  int         mon_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (wip === 1'b1) wip_hi++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: master samples MISO on SCK rise; each completed byte is checked.
  always @(posedge spi_sck or posedge spi_ss) begin
    if (spi_ss) begin
      mon_cnt = 0;
    end else if (spi_miso_oe === 1'b1) begin
      mon_sh = {mon_sh[6:0], spi_miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        sb_t e;
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_unexpected: got %0h want no output", mon_sh);
        end else begin
          e = exp_q.pop_front();
          if (e.mask != 8'h00) chk("miso_byte", {24'h0, mon_sh & e.mask}, {24'h0, e.exp & e.mask});
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wclk(HALF);
      spi_sck   = 1'b1;
      last_rise = cyc;
      wclk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic sel();
    spi_ss = 1'b0;
    wclk(HALF);
  endtask

  task automatic desel();
    wclk(HALF);
    spi_ss  = 1'b1;
    ss_rise = cyc;
    wclk(2 * HALF);
  endtask

  function automatic bit busy_at(input int t);
    return t < wip_until;
  endfunction

  function automatic logic [7:0] stat_mask(input int t);
    return (t > wip_until - 6 && t < wip_until + 6) ? 8'hFE : 8'hFF;
  endfunction

  task automatic do_wren(input bit en);
    int lc;
    sel();
    sbits(en ? 8'h06 : 8'h04, 8);
    lc = last_rise + 4;
    if (!busy_at(lc)) m_wel = en;
    desel();
  endtask

  task automatic do_rdsr(input int n);
    int lc;
    sel();
    sbits(8'h05, 8);
    for (int k = 0; k < n; k++) begin
      lc = last_rise + 4;
      exp_q.push_back(sb_t'({6'b0, m_wel, busy_at(lc), stat_mask(lc)}));
      sbits(8'($urandom), 8);
    end
    desel();
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    logic [7:0] idx;
    sel();
    sbits(8'h03, 8);
    sbits(a, 8);
    for (int k = 0; k < n; k++) begin
      idx = a + 8'(k);
      exp_q.push_back(sb_t'({ref_mem[idx], known[idx] ? 8'hFF : 8'h00}));
      sbits(8'($urandom), 8);
    end
    desel();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d[$], input int extra);
    int lc;
    bit acc;
    logic [7:0] ad;
    sel();
    sbits(8'h02, 8);
    lc  = last_rise + 4;
    acc = m_wel && !busy_at(lc);
    sbits(a, 8);
    ad = a;
    foreach (d[i]) begin
      sbits(d[i], 8);
      if (acc) begin
        ref_mem[ad] = d[i];
        known[ad]   = 1'b1;
        ad = (ad & ~8'(PS - 1)) | ((ad + 8'd1) & 8'(PS - 1));
      end
    end
    if (extra > 0) sbits(8'h77, extra);
    desel();
    if (acc && d.size() > 0) begin
      m_wel     = 1'b0;
      wip_until = ss_rise + 3 + W;
    end
  endtask

  task automatic wait_wip_low();
    for (int i = 0; i < 4 * W && wip !== 1'b0; i++) wclk(1);
    chk("wip_clear", {31'h0, wip}, 32'h0);
  endtask

  task automatic page_write(input logic [7:0] a, input int len, input bit check_len);
    logic [7:0] d[$];
    for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
    do_wren(1'b1);
    wip_hi = 0;
    do_write(a, d, 0);
    wait_wip_low();
    if (check_len) chk("wip_len", wip_hi, W);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] base;
    wclk(3);
    chk("rst_miso", {31'h0, spi_miso}, 0);
    chk("rst_oe", {31'h0, spi_miso_oe}, 0);
    chk("rst_wip", {31'h0, wip}, 0);
    rst = 1'b0;
    wclk(6);
    chk("post_rst_oe", {31'h0, spi_miso_oe}, 0);
    chk("post_rst_wip", {31'h0, wip}, 0);

    // Known contents for pages F0, 00, 10, 20 and a wrapping readback.
    page_write(8'hF0, 16, 1'b1);
    page_write(8'h00, 16, 1'b1);
    page_write(8'h10, 16, 1'b0);
    page_write(8'h20, 16, 1'b0);
    do_read(8'hF0, 48);

    // Randomly placed writes, many crossing the page end.
    for (int it = 0; it < 3; it++) begin
      base = 8'($urandom_range(0, 2)) << 4;
      page_write(base | 8'($urandom_range(0, 15)), $urandom_range(1, 20), 1'b0);
      do_read(base, 16);
    end

    // WREN; WRITE FE D3; WREN during busy is ignored; poll status.
    do_wren(1'b1);
    d = {8'hD3};
    wip_hi = 0;
    do_write(8'hFE, d, 0);
    chk("wip_high", {31'h0, wip}, 1);
    do_wren(1'b1);
    for (int k = 0; k < 20 && busy_at(cyc); k++) do_rdsr(1);
    wait_wip_low();
    chk("wip_len_fe", wip_hi, W);
    do_rdsr(2);
    do_read(8'hFE, 1);

    // WRITE without WEL is ignored.
    d = {8'h55};
    do_write(8'h10, d, 0);
    wclk(10);
    chk("nowel_wip", {31'h0, wip}, 0);
    do_read(8'h10, 1);

    // Page wrap: 0F then 00.
    do_wren(1'b1);
    d = {8'hAA, 8'hBB};
    do_write(8'h0F, d, 0);
    wait_wip_low();
    do_read(8'h0F, 1);
    do_read(8'h00, 1);

    // Read streaming across 0xFF, then idle outputs.
    do_read(8'hFF, 16);
    chk("desel_oe", {31'h0, spi_miso_oe}, 0);
    chk("desel_miso", {31'h0, spi_miso}, 0);

    // Partial data byte leaves memory, WIP and WEL alone.
    do_wren(1'b1);
    d = {};
    do_write(8'h20, d, 4);
    wclk(10);
    chk("partial_wip", {31'h0, wip}, 0);
    do_rdsr(1);
    do_read(8'h20, 1);

    // Reset in the middle of a READ.
    sel();
    sbits(8'h03, 8);
    sbits(8'hF0, 8);
    exp_q.push_back(sb_t'({ref_mem[8'hF0], 8'hFF}));
    sbits(8'h00, 3);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_miso", {31'h0, spi_miso}, 0);
    chk("midrst_oe", {31'h0, spi_miso_oe}, 0);
    chk("midrst_wip", {31'h0, wip}, 0);
    exp_q.delete();
    wclk(2);
    rst = 1'b0;
    m_wel = 1'b0;
    wip_until = 0;
    sbits(8'h05, 8);
    sbits(8'h00, 8);
    chk("unarmed_oe", {31'h0, spi_miso_oe}, 0);
    desel();
    do_rdsr(1);
    do_read(8'hF0, 2);

    wclk(10);
    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
